// File: rtl/board_attack_seq_pkg.sv
// Shared piece encoding, FSM state codes and move-offset tables for the attack-map generator.
// Piece code: bits [2:0] = kind, bit 3 set = black piece; code 0 = empty square.
package board_attack_seq_pkg;

  typedef logic [3:0] piece_t;

  localparam piece_t EMPTY_POSN  = 4'h0;
  localparam piece_t PAWN        = 4'h1;
  localparam piece_t KNIGHT      = 4'h2;
  localparam piece_t BISHOP      = 4'h3;
  localparam piece_t ROOK        = 4'h4;
  localparam piece_t QUEEN       = 4'h5;
  localparam piece_t KING        = 4'h6;
  localparam piece_t COLOUR_MASK = 4'h8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed {row,col} nibble pairs, entry i at [i*8 +: 8]; rays 0-3 orthogonal, 4-7 diagonal.
  localparam logic [63:0] RAY_DIRS    = {8'hFF, 8'hF1, 8'h1F, 8'h11, 8'h0F, 8'h01, 8'hF0, 8'h10};
  localparam logic [63:0] KNIGHT_OFFS = {8'hF2, 8'hE1, 8'hEF, 8'hFE, 8'h1E, 8'h2F, 8'h21, 8'h12};

  function automatic int off_row(logic [63:0] tbl, int i);
    return int'($signed(tbl[i*8+4 +: 4]));
  endfunction

  function automatic int off_col(logic [63:0] tbl, int i);
    return int'($signed(tbl[i*8 +: 4]));
  endfunction

  function automatic piece_t as_black(piece_t kind);
    return kind | COLOUR_MASK;
  endfunction

endpackage

// File: rtl/square_attack_eval.sv
// Combinational attack test for one target square: does any white / black piece attack it?
// The occupant of the target square is irrelevant; rays stop at the first occupied square.
module square_attack_eval
  import board_attack_seq_pkg::*;
#(
  parameter int PIECE_WIDTH = 4,
  parameter int BOARD_WIDTH = 64*PIECE_WIDTH
) (
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic [5:0]             square,
  output logic                   white_attacks,
  output logic                   black_attacks
);

  function automatic piece_t piece_at(logic [BOARD_WIDTH-1:0] b, int r, int c);
    return piece_t'(b[((r & 7)*8 + (c & 7))*PIECE_WIDTH +: PIECE_WIDTH]);
  endfunction

  function automatic logic on_board(int r, int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  always_comb begin
    int     r;
    int     c;
    int     rr;
    int     cc;
    logic   blocked;
    logic   slider;
    piece_t p;
    r             = int'(square[5:3]);
    c             = int'(square[2:0]);
    rr            = 0;
    cc            = 0;
    blocked       = 1'b0;
    slider        = 1'b0;
    p             = EMPTY_POSN;
    white_attacks = 1'b0;
    black_attacks = 1'b0;

    // White pawns sit one rank below the target, black pawns one rank above.
    for (int s = 0; s < 2; s++) begin
      cc = (s == 0) ? c - 1 : c + 1;
      if (on_board(r - 1, cc) && piece_at(board, r - 1, cc) == PAWN) white_attacks = 1'b1;
      if (on_board(r + 1, cc) && piece_at(board, r + 1, cc) == as_black(PAWN)) black_attacks = 1'b1;
    end

    for (int i = 0; i < 8; i++) begin
      rr = r + off_row(KNIGHT_OFFS, i);
      cc = c + off_col(KNIGHT_OFFS, i);
      if (on_board(rr, cc)) begin
        p = piece_at(board, rr, cc);
        if (p == KNIGHT) white_attacks = 1'b1;
        if (p == as_black(KNIGHT)) black_attacks = 1'b1;
      end
      rr = r + off_row(RAY_DIRS, i);
      cc = c + off_col(RAY_DIRS, i);
      if (on_board(rr, cc)) begin
        p = piece_at(board, rr, cc);
        if (p == KING) white_attacks = 1'b1;
        if (p == as_black(KING)) black_attacks = 1'b1;
      end
    end

    for (int d = 0; d < 8; d++) begin
      blocked = 1'b0;
      for (int k = 1; k < 8; k++) begin
        rr = r + k*off_row(RAY_DIRS, d);
        cc = c + k*off_col(RAY_DIRS, d);
        if (!blocked && on_board(rr, cc)) begin
          p = piece_at(board, rr, cc);
          if (p != EMPTY_POSN) begin
            blocked = 1'b1;
            slider  = (p[2:0] == QUEEN[2:0]) ||
                      ((d < 4) ? (p[2:0] == ROOK[2:0]) : (p[2:0] == BISHOP[2:0]));
            if (slider && !p[3]) white_attacks = 1'b1;
            if (slider && p[3])  black_attacks = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_attack_seq.sv
// Time-multiplexed attack-map generator: LANES squares per SCAN cycle over a latched board,
// then publishes both attack maps and in-check flags with a one-cycle done pulse.
module board_attack_seq
  import board_attack_seq_pkg::*;
#(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = 4,
  parameter int BOARD_WIDTH = 64*PIECE_WIDTH,
  parameter int LANES       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  output logic                   board_ready,
  output logic [63:0]            white_is_attacking,
  output logic [63:0]            black_is_attacking,
  output logic                   white_in_check,
  output logic                   black_in_check,
  output logic                   is_attacking_done,
  output logic                   attacking_valid
);

  localparam logic [5:0] LAST_IDX  = 6'(64 - LANES);
  localparam logic [5:0] LANE_STEP = 6'(LANES % 64);

  if (LANES < 1 || LANES > 64 || (64 % LANES) != 0 || SIDE_WIDTH < 1) begin : g_param_check
    $error("board_attack_seq: LANES must divide 64");
  end

  logic [1:0]             state_reg;
  logic [5:0]             idx_reg;
  logic [BOARD_WIDTH-1:0] board_reg;
  logic [63:0]            white_acc_reg, black_acc_reg;
  logic [63:0]            white_map_reg, black_map_reg;
  logic                   white_check_reg, black_check_reg;
  logic                   done_reg, valid_reg;

  logic [LANES-1:0]       lane_white, lane_black;
  logic [63:0]            white_scan_next, black_scan_next;
  logic                   white_check_next, black_check_next;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    square_attack_eval #(
      .PIECE_WIDTH(PIECE_WIDTH),
      .BOARD_WIDTH(BOARD_WIDTH)
    ) u_eval (
      .board        (board_reg),
      .square       (idx_reg + 6'(gi)),
      .white_attacks(lane_white[gi]),
      .black_attacks(lane_black[gi])
    );
  end

  always_comb begin
    white_scan_next = '0;
    black_scan_next = '0;
    for (int l = 0; l < LANES; l++) begin
      white_scan_next[idx_reg + 6'(l)] = lane_white[l];
      black_scan_next[idx_reg + 6'(l)] = lane_black[l];
    end
  end

  // Every king of a colour is checked, so boards with zero or several kings are handled.
  always_comb begin
    white_check_next = 1'b0;
    black_check_next = 1'b0;
    for (int s = 0; s < 64; s++) begin
      if (piece_t'(board_reg[s*PIECE_WIDTH +: PIECE_WIDTH]) == KING && black_acc_reg[s])
        white_check_next = 1'b1;
      if (piece_t'(board_reg[s*PIECE_WIDTH +: PIECE_WIDTH]) == as_black(KING) && white_acc_reg[s])
        black_check_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      board_reg       <= '0;
      white_acc_reg   <= '0;
      black_acc_reg   <= '0;
      white_map_reg   <= '0;
      black_map_reg   <= '0;
      white_check_reg <= 1'b0;
      black_check_reg <= 1'b0;
      done_reg        <= 1'b0;
      valid_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (board_valid) begin
            board_reg     <= board;
            white_acc_reg <= '0;
            black_acc_reg <= '0;
            idx_reg       <= '0;
            valid_reg     <= 1'b0;
            state_reg     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          white_acc_reg <= white_acc_reg | white_scan_next;
          black_acc_reg <= black_acc_reg | black_scan_next;
          if (idx_reg == LAST_IDX) state_reg <= ST_DONE;
          else                     idx_reg   <= idx_reg + LANE_STEP;
        end
        ST_DONE: begin
          white_map_reg   <= white_acc_reg;
          black_map_reg   <= black_acc_reg;
          white_check_reg <= white_check_next;
          black_check_reg <= black_check_next;
          done_reg        <= 1'b1;
          valid_reg       <= 1'b1;
          state_reg       <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign board_ready        = (state_reg == ST_IDLE);
  assign white_is_attacking = white_map_reg;
  assign black_is_attacking = black_map_reg;
  assign white_in_check     = white_check_reg;
  assign black_in_check     = black_check_reg;
  assign is_attacking_done  = done_reg;
  assign attacking_valid    = valid_reg;

endmodule

// File: tb/tb_board_attack_seq.sv
// Directed bench: four instances (LANES 1,4,8,64) share one board stream; checks maps, checks,
// done latency, mid-scan reset and back-to-back acceptance with board_valid held high.
module tb_board_attack_seq;

  localparam logic [3:0] W_PAWN = 4'h1, W_KNIGHT = 4'h2, W_ROOK = 4'h4, W_KING = 4'h6;
  localparam logic [3:0] B_PAWN = 4'h9, B_ROOK = 4'hC;

  typedef struct packed {
    logic [255:0] b;
    logic [63:0]  w;
    logic [63:0]  k;
    logic         wc;
    logic         bc;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] board = '0;
  logic         board_valid = 1'b0;
  logic         ready [4];
  logic [63:0]  wmap [4];
  logic [63:0]  bmap [4];
  logic         wchk [4];
  logic         bchk [4];
  logic         done [4];
  logic         valid [4];

  int   total = 0;
  int   bad = 0;
  vec_t vecs [6];
  int   lat [4];
  int   cnt [4];

  always #5 clk = ~clk;

  board_attack_seq #(.LANES(1)) u_l1 (.clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .board_ready(ready[0]), .white_is_attacking(wmap[0]), .black_is_attacking(bmap[0]),
    .white_in_check(wchk[0]), .black_in_check(bchk[0]), .is_attacking_done(done[0]), .attacking_valid(valid[0]));
  board_attack_seq #(.LANES(4)) u_l4 (.clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .board_ready(ready[1]), .white_is_attacking(wmap[1]), .black_is_attacking(bmap[1]),
    .white_in_check(wchk[1]), .black_in_check(bchk[1]), .is_attacking_done(done[1]), .attacking_valid(valid[1]));
  board_attack_seq #(.LANES(8)) u_l8 (.clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .board_ready(ready[2]), .white_is_attacking(wmap[2]), .black_is_attacking(bmap[2]),
    .white_in_check(wchk[2]), .black_in_check(bchk[2]), .is_attacking_done(done[2]), .attacking_valid(valid[2]));
  board_attack_seq #(.LANES(64)) u_l64 (.clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .board_ready(ready[3]), .white_is_attacking(wmap[3]), .black_is_attacking(bmap[3]),
    .white_in_check(wchk[3]), .black_in_check(bchk[3]), .is_attacking_done(done[3]), .attacking_valid(valid[3]));

  function automatic int lanes_of(int d);
    case (d)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 64;
    endcase
  endfunction

  function automatic logic [255:0] put(logic [255:0] b, int sq, logic [3:0] p);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = p;
    return r;
  endfunction

  task automatic chk(string what, int v, int d, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d lanes=%0d got=%h want=%h", what, v, lanes_of(d), act, exp);
    end
  endtask

  task automatic run_vec(int v);
    board       = vecs[v].b;
    board_valid = 1'b1;
    @(posedge clk); #1;
    board_valid = 1'b0;
    board       = '1;
    for (int d = 0; d < 4; d++) begin
      chk("valid_drop", v, d, 64'(valid[d]), 64'd0);
      lat[d] = 0;
      cnt[d] = 0;
    end
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (done[d]) begin
          cnt[d]++;
          if (lat[d] == 0) lat[d] = cyc;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      chk("latency", v, d, 64'(lat[d]), 64'(64/lanes_of(d) + 1));
      chk("done_pulses", v, d, 64'(cnt[d]), 64'd1);
      chk("white_map", v, d, wmap[d], vecs[v].w);
      chk("black_map", v, d, bmap[d], vecs[v].k);
      chk("white_check", v, d, 64'(wchk[d]), 64'(vecs[v].wc));
      chk("black_check", v, d, 64'(bchk[d]), 64'(vecs[v].bc));
      chk("valid_set", v, d, 64'(valid[d]), 64'd1);
      $display("vec %0d lanes=%0d latency=%0d white=%h black=%h wc=%b bc=%b",
               v, lanes_of(d), lat[d], wmap[d], bmap[d], wchk[d], bchk[d]);
    end
  endtask

  initial begin
    logic [255:0] b;
    int           exp_cnt;
    b = '0;
    vecs[0] = '{b: b, w: 64'h0, k: 64'h0, wc: 1'b0, bc: 1'b0};
    b = put('0, 0, W_ROOK);
    vecs[1] = '{b: b, w: 64'h01010101010101FE, k: 64'h0, wc: 1'b0, bc: 1'b0};
    b = put(b, 24, B_PAWN);
    vecs[2] = '{b: b, w: 64'h00000000010101FE, k: 64'h0000000000020000, wc: 1'b0, bc: 1'b0};
    b = put(put('0, 4, W_KING), 60, B_ROOK);
    vecs[3] = '{b: b, w: 64'h0000000000003828, k: 64'hEF10101010101010, wc: 1'b1, bc: 1'b0};
    b = put(b, 12, W_PAWN);
    vecs[4] = '{b: b, w: 64'h0000000000283828, k: 64'hEF10101010101000, wc: 1'b0, bc: 1'b0};
    b = put('0, 6, W_KNIGHT);
    vecs[5] = '{b: b, w: 64'h0000000000A01000, k: 64'h0, wc: 1'b0, bc: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_ready", -1, d, 64'(ready[d]), 64'd1);
      chk("rst_maps", -1, d, wmap[d] | bmap[d], 64'd0);
      chk("rst_flags", -1, d, 64'({wchk[d], bchk[d], done[d], valid[d]}), 64'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // Reset lands on the first SCAN edge of every instance, even the single-cycle one.
    board       = vecs[1].b;
    board_valid = 1'b1;
    @(posedge clk); #1;
    board_valid = 1'b0;
    reset       = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      chk("midrst_ready", 6, d, 64'(ready[d]), 64'd1);
      chk("midrst_maps", 6, d, wmap[d] | bmap[d], 64'd0);
      chk("midrst_flags", 6, d, 64'({wchk[d], bchk[d], done[d], valid[d]}), 64'd0);
      cnt[d] = 0;
    end
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) if (done[d]) cnt[d]++;
    end
    for (int d = 0; d < 4; d++) begin
      chk("midrst_no_done", 6, d, 64'(cnt[d]), 64'd0);
      $display("midrst lanes=%0d done_pulses=%0d valid=%b", lanes_of(d), cnt[d], valid[d]);
    end

    // board_valid held high: a new board is only taken each time the FSM revisits IDLE.
    board       = vecs[1].b;
    board_valid = 1'b1;
    for (int d = 0; d < 4; d++) cnt[d] = 0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) if (done[d]) cnt[d]++;
    end
    board_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      exp_cnt = 0;
      for (int k = 0; k*(64/lanes_of(d) + 2) + 64/lanes_of(d) + 1 <= 30; k++) exp_cnt++;
      chk("hold_done_count", 7, d, 64'(cnt[d]), 64'(exp_cnt));
    end
    repeat (70) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("hold_white_map", 7, d, wmap[d], vecs[1].w);
      chk("hold_valid", 7, d, 64'(valid[d]), 64'd1);
      $display("hold lanes=%0d done_pulses=%0d white=%h", lanes_of(d), cnt[d], wmap[d]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
